// File: rtl/relu_maxpool2x2_pkg.sv
// Shared definitions for the CNN pixel pipeline: sample width, ReLU, unsigned max, FSM states.
package cnn_pkg;

  localparam int unsigned bit_depth = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVEN = 2'd1,
    ODD  = 2'd2
  } state_t;

  // Negative samples clamp to zero; everything downstream treats values as unsigned.
  function automatic logic [bit_depth-1:0] relu(input logic [bit_depth-1:0] x);
    return x[bit_depth-1] ? '0 : x;
  endfunction

  function automatic logic [bit_depth-1:0] umax(input logic [bit_depth-1:0] a,
                                                input logic [bit_depth-1:0] b);
    return (a >= b) ? a : b;
  endfunction

endpackage

// File: rtl/relu_maxpool2x2_if.sv
// Pixel stream bundle: conv samples in, pooled pixels and status out.
interface relu_maxpool2x2_if;
  import cnn_pkg::*;

  logic                 de;
  logic [bit_depth-1:0] in;
  logic                 out_de;
  logic [bit_depth-1:0] result;
  logic                 frame_done;
  logic                 overrun;

  modport master (output de, in, input out_de, result, frame_done, overrun);
  modport slave  (input de, in, output out_de, result, frame_done, overrun);

endinterface

// File: rtl/relu_maxpool2x2_pool_line_buf.sv
// Simple dual-port line buffer holding horizontal maxima of the even row.
// Combinational read so the odd-row compare completes in the sampling cycle.
module pool_line_buf #(
  parameter int unsigned DEPTH = 13,
  parameter int unsigned AW    = 4,
  parameter int unsigned W     = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [DEPTH];

  // Write port: one horizontal max per even-row pair.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/relu_maxpool2x2.sv
// ReLU followed by 2x2 stride-2 max pooling on a line-structured sample stream.
module relu_maxpool2x2
  import cnn_pkg::*;
#(
  parameter int unsigned IMG_W = 26,
  parameter int unsigned IMG_H = 26,
  parameter int unsigned AW    = $clog2(IMG_W/2)
) (
  input  logic               clk,
  input  logic               RESET,
  input  logic               start,
  relu_maxpool2x2_if.slave   bus
);

  localparam int unsigned CW       = $clog2(IMG_W+1);
  localparam int unsigned RW       = $clog2(IMG_H+1);
  localparam int unsigned LAST_ODD = 2*(IMG_H/2) - 1;

  state_t               state;
  logic [CW-1:0]        col;
  logic [RW-1:0]        row;
  logic [bit_depth-1:0] h_reg;
  logic                 de_d;

  logic                 active, accept, fall, col_full, odd_col;
  logic                 frame_end, tail_end, buf_we;
  logic [bit_depth-1:0] r, hmax, rd_data;
  logic [AW-1:0]        buf_addr;

  // Acceptance, line-end detection and the horizontal compare.
  always_comb begin
    active    = (state != IDLE);
    col_full  = (col == CW'(IMG_W));
    accept    = active && bus.de && !col_full;
    fall      = active && !bus.de && de_d;
    odd_col   = col[0];
    r         = relu(bus.in);
    hmax      = umax(h_reg, r);
    buf_addr  = AW'(col >> 1);
    buf_we    = accept && odd_col && (state == EVEN);
    frame_end = (state == ODD)  && (row == RW'(LAST_ODD));
    // Only reachable for odd IMG_H: the unpaired last line of the frame.
    tail_end  = (state == EVEN) && (row == RW'(IMG_H-1));
  end

  pool_line_buf #(
    .DEPTH (IMG_W/2),
    .AW    (AW),
    .W     (bit_depth)
  ) u_line_buf (
    .clk     (clk),
    .we      (buf_we),
    .wr_addr (buf_addr),
    .wr_data (hmax),
    .rd_addr (buf_addr),
    .rd_data (rd_data)
  );

  // Row/column counters and EVEN/ODD line sequencing.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;
      col   <= '0;
      row   <= '0;
      h_reg <= '0;
      de_d  <= 1'b0;
    end else if (!start) begin
      state <= IDLE;
      col   <= '0;
      row   <= '0;
      h_reg <= '0;
      de_d  <= 1'b0;
    end else begin
      de_d <= active && bus.de;
      if (state == IDLE) state <= EVEN;
      if (accept) begin
        col <= col + 1'b1;
        if (!odd_col) h_reg <= r;
      end
      if (fall) begin
        col <= '0;
        if (frame_end) begin
          state <= EVEN;
          // With odd IMG_H one more (discarded) even line follows before wrapping.
          if (IMG_H % 2 == 1) row <= row + 1'b1;
          else                row <= '0;
        end else if (tail_end) begin
          state <= EVEN;
          row   <= '0;
        end else begin
          row   <= row + 1'b1;
          state <= (state == EVEN) ? ODD : EVEN;
        end
      end
    end
  end

  // Pooled output, frame completion pulse and sticky overrun flag.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      bus.out_de     <= 1'b0;
      bus.result     <= '0;
      bus.frame_done <= 1'b0;
      bus.overrun    <= 1'b0;
    end else if (!start) begin
      bus.out_de     <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.overrun    <= 1'b0;
    end else begin
      bus.out_de     <= 1'b0;
      bus.frame_done <= fall && frame_end;
      if (accept && odd_col && (state == ODD)) begin
        bus.result <= umax(rd_data, hmax);
        bus.out_de <= 1'b1;
      end
      if (active && bus.de && col_full) bus.overrun <= 1'b1;
    end
  end

endmodule
